branch_control: RTL and testbench

- Consumer end of the fetch unit's branch interface. Takes the instruction the fetch unit just delivered, decodes the branch class, and evaluates the condition.
- Drives UncondBr and BrTaken back to the fetch unit in the same cycle.
- Owns the architectural NZCV flag register, written by flag-setting ALU ops. Flags a halt on branch-to-self so benches can stop simulation.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_control_cond_eval.sv | 33 +++
 rtl/branch_control.sv | 97 +++++++++
 tb/tb_branch_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and opcode constants for the branch control block.
package branch_pkg;

  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [5:0] OP_BL    = 6'b100101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_CBNZ  = 8'b10110101;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, HS = 4'b0010, LO = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} br_state_e;

endpackage

// File: rtl/branch_control_cond_eval.sv
// Combinational condition-code evaluator: maps (cond, NZCV) to a taken decision.
module cond_eval
  import branch_pkg::*;
(
  input  cond_e  cond,
  input  flags_t f,
  output logic   taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      EQ: taken = f.z;
      NE: taken = !f.z;
      HS: taken = f.c;
      LO: taken = !f.c;
      MI: taken = f.n;
      PL: taken = !f.n;
      VS: taken = f.v;
      VC: taken = !f.v;
      HI: taken = f.c && !f.z;
      LS: taken = !f.c || f.z;
      GE: taken = (f.n == f.v);
      LT: taken = (f.n != f.v);
      GT: taken = !f.z && (f.n == f.v);
      LE: taken = f.z || (f.n != f.v);
      AL: taken = 1'b1;
      NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_control.sv
// Branch decode/evaluate, NZCV flag register and sticky branch-to-self halt.
// Optional BRANCH_STATS_EN adds saturating branch / taken-branch counters.
module branch_control
  import branch_pkg::*;
#(
  parameter int HALT_DETECT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        rt_zero,
  input  logic        flag_write,
  input  logic [3:0]  alu_flags,
  output logic        UncondBr,
  output logic        BrTaken,
  output logic        link_write,
  output logic [3:0]  flags,
  output logic        halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
`endif
);

  flags_t    flag_q;
  br_state_e state, state_next;

  logic is_b, is_bl, is_bcond, is_cbz, is_cbnz, is_branch;
  logic cond_taken, self_branch;

  assign is_b      = (instruction[31:26] == OP_B);
  assign is_bl     = (instruction[31:26] == OP_BL);
  assign is_bcond  = (instruction[31:24] == OP_BCOND);
  assign is_cbz    = (instruction[31:24] == OP_CBZ);
  assign is_cbnz   = (instruction[31:24] == OP_CBNZ);
  assign is_branch = is_b || is_bl || is_bcond || is_cbz || is_cbnz;

  // B.cond sees only the registered flags; a same-cycle flag write is not forwarded.
  cond_eval u_cond_eval (
    .cond  (cond_e'(instruction[3:0])),
    .f     (flag_q),
    .taken (cond_taken)
  );

  always_comb begin
    UncondBr   = 1'b0;
    BrTaken    = 1'b0;
    link_write = 1'b0;
    if (!reset) begin
      UncondBr   = is_b || is_bl;
      link_write = is_bl;
      if (is_b || is_bl)  BrTaken = 1'b1;
      else if (is_cbz)    BrTaken = rt_zero;
      else if (is_cbnz)   BrTaken = !rt_zero;
      else if (is_bcond)  BrTaken = cond_taken;
    end
  end

  assign self_branch = (HALT_DETECT != 0) && is_b && (instruction[25:0] == 26'd0);

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (self_branch) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      flag_q <= '0;
    end else begin
      state <= state_next;
      if (flag_write) flag_q <= flags_t'(alu_flags);
    end
  end

  assign flags  = flag_q;
  assign halted = (state == HALT);

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else if (state == RUN && is_branch) begin
      if (br_count != 32'hFFFF_FFFF) br_count <= br_count + 32'd1;
      if (BrTaken && br_taken_count != 32'hFFFF_FFFF)
        br_taken_count <= br_taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_control.sv
// Directed plus randomized bench for branch_control, checked against a behavioural model.
module tb_branch_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        rt_zero;
  logic        flag_write;
  logic [3:0]  alu_flags;
  logic        UncondBr, BrTaken, link_write, halted;
  logic [3:0]  flags;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, br_taken_count;
`endif

  logic [3:0] ce_cond;
  logic [3:0] ce_flags;
  logic       ce_taken;

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_flags;
  logic        m_halted;
  logic [31:0] m_cnt, m_tcnt;

  always #5 clk = ~clk;

  branch_control dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .rt_zero     (rt_zero),
    .flag_write  (flag_write),
    .alu_flags   (alu_flags),
    .UncondBr    (UncondBr),
    .BrTaken     (BrTaken),
    .link_write  (link_write),
    .flags       (flags),
    .halted      (halted)
`ifdef BRANCH_STATS_EN
    ,
    .br_count       (br_count),
    .br_taken_count (br_taken_count)
`endif
  );

  cond_eval u_ce (
    .cond  (branch_pkg::cond_e'(ce_cond)),
    .f     (branch_pkg::flags_t'(ce_flags)),
    .taken (ce_taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Condition semantics: even codes name a base test, odd codes invert it; 111x always taken.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] != 3'd7) base = base ^ c[0];
    return base;
  endfunction

  task automatic cycle(input logic [31:0] ins, input logic rz, input logic fw,
                       input logic [3:0] af, input logic rst);
    logic [5:0] op6;
    logic [7:0] op8;
    logic br, e_unc, e_tk, e_lnk;
    instruction = ins;
    rt_zero     = rz;
    flag_write  = fw;
    alu_flags   = af;
    reset       = rst;
    op6 = ins[31:26];
    op8 = ins[31:24];
    br = 1'b1; e_unc = 1'b0; e_tk = 1'b0; e_lnk = 1'b0;
    if (op6 == 6'd5)            begin e_unc = 1'b1; e_tk = 1'b1; end
    else if (op6 == 6'd37)      begin e_unc = 1'b1; e_tk = 1'b1; e_lnk = 1'b1; end
    else if (op8 == 8'h54)      e_tk = ref_cond(ins[3:0], m_flags);
    else if (op8 == 8'hB4)      e_tk = rz;
    else if (op8 == 8'hB5)      e_tk = !rz;
    else                        br = 1'b0;
    if (rst) begin e_unc = 1'b0; e_tk = 1'b0; e_lnk = 1'b0; end
    @(negedge clk);
    check("UncondBr", 32'(UncondBr), 32'(e_unc));
    check("BrTaken", 32'(BrTaken), 32'(e_tk));
    check("link_write", 32'(link_write), 32'(e_lnk));
    check("flags", 32'(flags), 32'(m_flags));
    check("halted", 32'(halted), 32'(m_halted));
`ifdef BRANCH_STATS_EN
    check("br_count", br_count, m_cnt);
    check("br_taken_count", br_taken_count, m_tcnt);
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      m_flags = 4'b0000; m_halted = 1'b0; m_cnt = 0; m_tcnt = 0;
    end else begin
      if (!m_halted && br) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (e_tk && m_tcnt != 32'hFFFF_FFFF) m_tcnt++;
      end
      if (fw) m_flags = af;
      if (op6 == 6'd5 && ins[25:0] == 26'd0) m_halted = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: begin
        r = {6'b000101, r[25:0]};
        if (r[25:0] == 26'd0 || $urandom_range(0, 60) != 0) r[0] = 1'b1;
        else r[25:0] = 26'd0;
      end
      1: r = {6'b100101, r[25:0]};
      2, 3: r = {8'h54, r[23:0]};
      4: r = {8'hB4, r[23:0]};
      5: r = {8'hB5, r[23:0]};
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b1; instruction = 32'h1400_0004; rt_zero = 1'b0;
    flag_write = 1'b0; alu_flags = 4'b0000;
    ce_cond = 4'd0; ce_flags = 4'd0;
    m_flags = 4'b0000; m_halted = 1'b0; m_cnt = 0; m_tcnt = 0;
    @(posedge clk);
    #1;

    // Reset held two cycles with B #4, then released.
    cycle(32'h1400_0004, 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(32'h1400_0004, 1'b0, 1'b0, 4'b0000, 1'b1);
    check("reset_flags", 32'(flags), 32'h0);
    cycle(32'h1400_0004, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Flag set then B.EQ, both polarities.
    cycle(32'h8B02_0020, 1'b0, 1'b1, 4'b0100, 1'b0);
    check("flags_z_set", 32'(flags), 32'h4);
    cycle(32'h5400_0040, 1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(32'h8B02_0020, 1'b0, 1'b1, 4'b0000, 1'b0);
    cycle(32'h5400_0040, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Same-cycle flag write is not forwarded to B.EQ.
    cycle(32'h5400_0040, 1'b0, 1'b1, 4'b0100, 1'b0);
    check("flags_after_nofwd", 32'(flags), 32'h4);

    // CBZ / CBNZ, BL, non-branch ADD.
    cycle(32'hB400_0081, 1'b1, 1'b0, 4'b0000, 1'b0);
    cycle(32'hB400_0081, 1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(32'hB500_0081, 1'b1, 1'b0, 4'b0000, 1'b0);
    cycle(32'hB500_0081, 1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(32'h9400_0010, 1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(32'h8B02_0020, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Randomized traffic with occasional resets and rare branch-to-self.
    for (int i = 0; i < 400; i++) begin
      cycle(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 24) == 0));
    end
    cycle(32'h8B02_0020, 1'b0, 1'b0, 4'b0000, 1'b1);

    // Halt: sticky under following instructions, cleared by one reset edge.
    cycle(32'h1400_0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("halted_set", 32'(halted), 32'h1);
    cycle(32'h8B02_0020, 1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(32'h1400_0004, 1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(32'hB400_0081, 1'b1, 1'b0, 4'b0000, 1'b0);
    check("halted_held", 32'(halted), 32'h1);
    cycle(32'h8B02_0020, 1'b0, 1'b0, 4'b0000, 1'b1);
    check("halted_cleared", 32'(halted), 32'h0);
    cycle(32'h1400_0004, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Exhaustive condition evaluator sweep.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        ce_cond = 4'(c);
        ce_flags = 4'(f);
        #1;
        check("cond_eval", 32'(ce_taken), 32'(ref_cond(4'(c), 4'(f))));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
